decode_issue: RTL and testbench
===============================

Name: decode_issue

Overview:
- Registered successor to the combinational decode stage.
- Decodes the fetched instruction and reads register operands.
- Resolves operand forwarding from NFWD producer stages, ordered by priority.
- Detects load-use hazards and holds the instruction, inserting bubbles downstream.
- Captures the result in an ID/EX pipeline register guarded by valid/ready handshakes.
- Sits between fetch and execute.

Parameters:
- XLEN, 64: operand/data width.
- NFWD, 3: number of forwarding sources. Index 0 is the youngest producer and has the highest priority.
- RADDR_W, 5: register address width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  dataF holds a valid instruction.
- in_ready  out  1  stage accepts dataF this cycle.
- dataF  in  fetch_data_t  fetched instruction.
- ra1, ra2  out  RADDR_W  regfile read addresses, taken combinationally from instr[19:15] and instr[24:20].
- rd1, rd2  in  XLEN  regfile read data.
- fwd_valid  in  NFWD  producer i writes a register.
- fwd_dst  in  NFWD*RADDR_W  destination of producer i.
- fwd_data  in  NFWD*XLEN  result of producer i.
- fwd_pending  in  NFWD  producer i's result is not yet available (load in EX).
- flush  in  1  kill the held and incoming instruction.
- out_valid  out  1  dataD is valid.
- out_ready  in  1  execute accepts dataD.
- dataD  out  decode_data_t  registered decode result: ctl, imm, dst, rs1, rs2, srca, srcb, instr.

Behaviour:
- Reset: out_valid=0, dataD=all zeros, FSM=EMPTY. in_ready is 0 during the reset cycle.
- Forward select, per operand:
  - Operand address 0 is never forwarded; its value is forced to 0.
  - Otherwise pick the lowest i with fwd_valid[i] and fwd_dst[i]==addr.
  - If none matches, use rd1/rd2.
- hazard = in_valid and, for either operand, the selected producer has fwd_pending=1. Lower-priority sources are ignored once a match is found.
- can_advance = !out_valid || out_ready.
- in_ready = can_advance && !hazard && !flush.
- FSM states EMPTY (out_valid=0) and FULL (out_valid=1). Transitions evaluated each cycle, in priority order:
  - flush: go to EMPTY. Nothing is captured, regardless of other inputs.
  - in_valid && in_ready: capture the decoded fields and selected operands into dataD; go to FULL. Latency is 1 cycle from acceptance to out_valid.
  - hazard && can_advance: bubble, go to EMPTY. The instruction stays on dataF and is retried the next cycle.
  - FULL && out_ready with no capture: go to EMPTY.
  - FULL && !out_ready: hold dataD and stay FULL. Operands were frozen at capture, so later producer retirement does not affect them.
- Simultaneous hand-off: out_ready with a new capture in the same cycle gives back-to-back FULL, one instruction per cycle.
- dataD changes only on capture or reset. In EMPTY the bubble has ctl fields zeroed.
- Reset asserted mid-hold discards the held instruction.

Optional Feature:
- DECODE_ISSUE_PERF_EN.
- When defined:
  - Adds outputs stall_cycles and bubble_count (64 bits each), reset to 0.
  - stall_cycles increments each cycle with in_valid && !in_ready && !flush.
  - bubble_count increments on each hazard-induced transition to EMPTY.
  - Both counters saturate at all-ones.
- When undefined: the ports and counters are absent. Functional behaviour is identical.

Decomposition:
- pipes package: decode_data_t (unchanged) and a new fwd_src_t struct (valid, dst, data, pending) for a packed-array form of the forwarding ports.
- common package: XLEN-derived word_t, creg_addr_t.
- Instantiates the existing decoder for imm/ctl.
- Natural sub-module: fwd_select. It is combinational, instantiated twice, and outputs the value and a pending flag.

Test Plan:
- Reset then idle: out_valid=0, dataD=0. First valid add x3,x1,x2 with rd1=5, rd2=7 and no forwarding gives out_valid=1 next cycle with srca=5, srcb=7.
- Priority: fwd 0 and fwd 2 both target x1 with data 0xAA and 0xBB; rs1=x1 gives srca=0xAA. rs1=x0 with fwd_dst[0]=0 gives srca=0.
- Load-use: fwd_pending[0]=1 for x1, rs1=x1.
  - Pending cycle: in_ready=0, out_valid drops to 0.
  - Next cycle, pending cleared with data 0x10: instruction captured, srca=0x10.
- Backpressure: out_ready=0 for 3 cycles while FULL. dataD and srca stay constant and in_ready=0. When out_ready returns to 1, the next instruction is captured in that cycle.
- Flush with in_valid=1, FULL: out_valid=0 next cycle and the incoming instruction is not captured.
- PERF_EN: a 2-cycle load-use stall plus a 1-cycle backpressure cycle gives stall_cycles=3, bubble_count=2.

Source files
------------

// File: rtl/decode_issue_pkg.sv
// Shared types for the decode/issue stage: fetch/decode payloads, forwarding sources,
// control-field decode helpers.
package decode_issue_pkg;

  localparam int DI_XLEN    = 64;
  localparam int DI_RADDR_W = 5;
  localparam int DI_NFWD    = 3;
  localparam int ILEN       = 32;

  typedef logic [DI_XLEN-1:0]    word_t;
  typedef logic [DI_RADDR_W-1:0] creg_addr_t;
  typedef logic [ILEN-1:0]       instr_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef enum logic {ST_EMPTY, ST_FULL} state_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    use_imm;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
  } ctl_t;

  typedef struct packed {
    instr_t instr;
  } fetch_data_t;

  typedef struct packed {
    ctl_t       ctl;
    word_t      imm;
    creg_addr_t dst;
    creg_addr_t rs1;
    creg_addr_t rs2;
    word_t      srca;
    word_t      srcb;
    instr_t     instr;
  } decode_data_t;

  typedef struct packed {
    logic       valid;
    creg_addr_t dst;
    word_t      data;
    logic       pending;
  } fwd_src_t;

  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Unknown opcodes decode to an all-zero control word, i.e. a no-op.
  function automatic ctl_t decode_ctl(input instr_t instr);
    ctl_t c;
    c = '0;
    case (instr[6:0])
      OPC_OP: begin
        c.reg_write = 1'b1;
        c.alu_op    = alu_from_f3(instr[14:12], instr[30]);
      end
      OPC_OPIMM: begin
        c.reg_write = 1'b1;
        c.use_imm   = 1'b1;
        c.alu_op    = alu_from_f3(instr[14:12], (instr[14:12] == 3'b101) && instr[30]);
      end
      OPC_LOAD: begin
        c.reg_write = 1'b1;
        c.use_imm   = 1'b1;
        c.mem_read  = 1'b1;
      end
      OPC_STORE: begin
        c.use_imm   = 1'b1;
        c.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      OPC_LUI: begin
        c.reg_write = 1'b1;
        c.use_imm   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic word_t decode_imm(input instr_t instr);
    word_t imm;
    case (instr[6:0])
      OPC_OPIMM, OPC_LOAD: imm = {{(DI_XLEN-12){instr[31]}}, instr[31:20]};
      OPC_STORE:           imm = {{(DI_XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:          imm = {{(DI_XLEN-13){instr[31]}}, instr[31], instr[7],
                                  instr[30:25], instr[11:8], 1'b0};
      OPC_LUI:             imm = {{(DI_XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      default:             imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_issue_fwd_select.sv
// Combinational operand forwarding: lowest-index matching producer wins, x0 reads as zero.
// Reports whether the chosen producer's result is still pending.
module decode_issue_fwd_select
  import decode_issue_pkg::*;
#(
  parameter int NFWD = DI_NFWD
) (
  input  creg_addr_t            addr,
  input  word_t                 reg_data,
  input  fwd_src_t [NFWD-1:0]   src,
  output word_t                 value,
  output logic                  pending
);

  logic found;

  always_comb begin
    value   = reg_data;
    pending = 1'b0;
    found   = 1'b0;
    if (addr == '0) begin
      value = '0;
    end else begin
      for (int i = 0; i < NFWD; i++) begin
        if (!found && src[i].valid && (src[i].dst == addr)) begin
          found   = 1'b1;
          value   = src[i].data;
          pending = src[i].pending;
        end
      end
    end
  end

endmodule

// File: rtl/decode_issue.sv
// Registered decode/issue stage with forwarding and load-use stall; 1 cycle accept-to-out_valid.
// Holds dataD under out_ready=0; optional perf counters with DECODE_ISSUE_PERF_EN.
module decode_issue
  import decode_issue_pkg::*;
#(
  parameter int XLEN    = DI_XLEN,
  parameter int NFWD    = DI_NFWD,
  parameter int RADDR_W = DI_RADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  fetch_data_t             dataF,
  output logic [RADDR_W-1:0]      ra1,
  output logic [RADDR_W-1:0]      ra2,
  input  logic [XLEN-1:0]         rd1,
  input  logic [XLEN-1:0]         rd2,
  input  logic [NFWD-1:0]         fwd_valid,
  input  logic [NFWD*RADDR_W-1:0] fwd_dst,
  input  logic [NFWD*XLEN-1:0]    fwd_data,
  input  logic [NFWD-1:0]         fwd_pending,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output decode_data_t            dataD
`ifdef DECODE_ISSUE_PERF_EN
  ,
  output logic [63:0]             stall_cycles,
  output logic [63:0]             bubble_count
`endif
);

  fwd_src_t [NFWD-1:0] fwd_src;
  word_t               srca, srcb;
  logic                pend_a, pend_b;
  logic                hazard, can_advance, capture, bubble;
  decode_data_t        dec_data;
  decode_data_t        data_d, data_q;
  state_t              state_d, state_q;

  assign ra1 = dataF.instr[19:15];
  assign ra2 = dataF.instr[24:20];

  always_comb begin
    fwd_src = '0;
    for (int i = 0; i < NFWD; i++) begin
      fwd_src[i].valid   = fwd_valid[i];
      fwd_src[i].dst     = fwd_dst[i*RADDR_W +: RADDR_W];
      fwd_src[i].data    = fwd_data[i*XLEN +: XLEN];
      fwd_src[i].pending = fwd_pending[i];
    end
  end

  decode_issue_fwd_select #(.NFWD(NFWD)) u_fwd_a (
    .addr     (dataF.instr[19:15]),
    .reg_data (rd1),
    .src      (fwd_src),
    .value    (srca),
    .pending  (pend_a)
  );

  decode_issue_fwd_select #(.NFWD(NFWD)) u_fwd_b (
    .addr     (dataF.instr[24:20]),
    .reg_data (rd2),
    .src      (fwd_src),
    .value    (srcb),
    .pending  (pend_b)
  );

  always_comb begin
    dec_data       = '0;
    dec_data.ctl   = decode_ctl(dataF.instr);
    dec_data.imm   = decode_imm(dataF.instr);
    dec_data.rs1   = dataF.instr[19:15];
    dec_data.rs2   = dataF.instr[24:20];
    dec_data.dst   = dec_data.ctl.reg_write ? dataF.instr[11:7] : '0;
    dec_data.srca  = srca;
    dec_data.srcb  = srcb;
    dec_data.instr = dataF.instr;
  end

  assign out_valid   = (state_q == ST_FULL);
  assign hazard      = in_valid && (pend_a || pend_b);
  assign can_advance = !out_valid || out_ready;
  assign in_ready    = !reset && can_advance && !hazard && !flush;
  assign capture     = !flush && in_valid && in_ready;
  assign bubble      = !flush && hazard && can_advance;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (capture) begin
      state_d = ST_FULL;
      data_d  = dec_data;
    end else if (bubble) begin
      state_d = ST_EMPTY;
    end else if ((state_q == ST_FULL) && out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // The payload register only moves on capture; a bubble is signalled by masking ctl.
  always_comb begin
    dataD = data_q;
    if (state_q == ST_EMPTY) dataD.ctl = '0;
  end

`ifdef DECODE_ISSUE_PERF_EN
  logic [63:0] stall_d, stall_q, bubble_d, bubble_q;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (in_valid && !in_ready && !flush && (stall_q != '1)) stall_d = stall_q + 64'd1;
    if (bubble && (bubble_q != '1)) bubble_d = bubble_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cycles = stall_q;
  assign bubble_count = bubble_q;
`endif

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: reset, forwarding priority, load-use, backpressure, flush.
module tb_decode_issue;
  import decode_issue_pkg::*;

  localparam instr_t I_ADD   = 32'h002081B3; // add  x3,x1,x2
  localparam instr_t I_SUB   = 32'h402082B3; // sub  x5,x1,x2
  localparam instr_t I_ADDX0 = 32'h002001B3; // add  x3,x0,x2
  localparam instr_t I_ADDI  = 32'h00708213; // addi x4,x1,7

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, flush, out_valid, out_ready;
  fetch_data_t   dataF;
  logic [4:0]    ra1, ra2;
  logic [63:0]   rd1, rd2;
  logic [2:0]    fwd_valid, fwd_pending;
  logic [14:0]   fwd_dst;
  logic [191:0]  fwd_data;
  decode_data_t  dataD;
`ifdef DECODE_ISSUE_PERF_EN
  logic [63:0]   stall_cycles, bubble_count;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  decode_issue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .dataF(dataF),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .dataD(dataD)
`ifdef DECODE_ISSUE_PERF_EN
    , .stall_cycles(stall_cycles), .bubble_count(bubble_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    fwd_valid = '0; fwd_pending = '0; fwd_dst = '0; fwd_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; dataF.instr = I_ADD; out_ready = 1'b1; flush = 1'b0;
    rd1 = 64'd5; rd2 = 64'd7; clear_fwd();
    #1;
    vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tick();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vec_cnt++; if (dataD !== '0) begin err_cnt++; $display("FAIL reset_dataD: got %h want 0", dataD); end
    reset = 1'b0; in_valid = 1'b0;
    tick();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL idle_out_valid: got %b want 0", out_valid); end
    vec_cnt++; if (dataD !== '0) begin err_cnt++; $display("FAIL idle_dataD: got %h want 0", dataD); end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; dataF.instr = I_ADD; rd1 = 64'd5; rd2 = 64'd7;
    #1;
    vec_cnt++; if (ra1 !== 5'd1) begin err_cnt++; $display("FAIL basic_ra1: got %0d want 1", ra1); end
    vec_cnt++; if (ra2 !== 5'd2) begin err_cnt++; $display("FAIL basic_ra2: got %0d want 2", ra2); end
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    tick();
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
    vec_cnt++; if (dataD.srca !== 64'd5) begin err_cnt++; $display("FAIL basic_srca: got %h want 5", dataD.srca); end
    vec_cnt++; if (dataD.srcb !== 64'd7) begin err_cnt++; $display("FAIL basic_srcb: got %h want 7", dataD.srcb); end
    vec_cnt++; if (dataD.dst !== 5'd3) begin err_cnt++; $display("FAIL basic_dst: got %0d want 3", dataD.dst); end
    vec_cnt++; if (dataD.ctl.reg_write !== 1'b1) begin err_cnt++; $display("FAIL basic_reg_write: got %b want 1", dataD.ctl.reg_write); end
    // back-to-back hand-off while FULL with out_ready=1
    dataF.instr = I_SUB; rd1 = 64'hB; rd2 = 64'd3;
    #1;
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    tick();
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_out_valid: got %b want 1", out_valid); end
    vec_cnt++; if (dataD.srca !== 64'hB) begin err_cnt++; $display("FAIL b2b_srca: got %h want b", dataD.srca); end
    vec_cnt++; if (dataD.dst !== 5'd5) begin err_cnt++; $display("FAIL b2b_dst: got %0d want 5", dataD.dst); end
    vec_cnt++; if (dataD.ctl.alu_op !== ALU_SUB) begin err_cnt++; $display("FAIL b2b_alu_op: got %0d want %0d", dataD.ctl.alu_op, ALU_SUB); end
    in_valid = 1'b0;
    tick();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL drain_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_priority();
    in_valid = 1'b1; dataF.instr = I_ADD; rd1 = 64'd5; rd2 = 64'd7;
    fwd_valid = 3'b101; fwd_dst[4:0] = 5'd1; fwd_dst[14:10] = 5'd1;
    fwd_data[63:0] = 64'hAA; fwd_data[191:128] = 64'hBB;
    tick();
    vec_cnt++; if (dataD.srca !== 64'hAA) begin err_cnt++; $display("FAIL prio_srca: got %h want aa", dataD.srca); end
    vec_cnt++; if (dataD.srcb !== 64'd7) begin err_cnt++; $display("FAIL prio_srcb: got %h want 7", dataD.srcb); end
    clear_fwd();
    dataF.instr = I_ADDX0; rd1 = 64'h55; fwd_valid = 3'b001; fwd_dst[4:0] = 5'd0; fwd_data[63:0] = 64'hCC;
    tick();
    vec_cnt++; if (dataD.srca !== 64'd0) begin err_cnt++; $display("FAIL x0_srca: got %h want 0", dataD.srca); end
    clear_fwd();
    dataF.instr = I_ADD; rd1 = 64'd5;
    fwd_valid = 3'b110; fwd_dst[9:5] = 5'd1; fwd_dst[14:10] = 5'd1;
    fwd_data[127:64] = 64'h11; fwd_data[191:128] = 64'h22; fwd_pending = 3'b100;
    #1;
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL shadow_pend_in_ready: got %b want 1", in_ready); end
    tick();
    vec_cnt++; if (dataD.srca !== 64'h11) begin err_cnt++; $display("FAIL prio1_srca: got %h want 11", dataD.srca); end
    in_valid = 1'b0; clear_fwd();
    tick();
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; dataF.instr = I_ADD; rd1 = 64'd5; rd2 = 64'd7;
    tick();
    fwd_valid = 3'b001; fwd_dst[4:0] = 5'd1; fwd_pending = 3'b001; fwd_data[63:0] = 64'hDEAD;
    #1;
    vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL lu_in_ready: got %b want 0", in_ready); end
    tick();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL lu_bubble_valid: got %b want 0", out_valid); end
    vec_cnt++; if (dataD.ctl !== '0) begin err_cnt++; $display("FAIL lu_bubble_ctl: got %h want 0", dataD.ctl); end
    fwd_pending = 3'b000; fwd_data[63:0] = 64'h10;
    #1;
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL lu_retry_in_ready: got %b want 1", in_ready); end
    tick();
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL lu_retry_valid: got %b want 1", out_valid); end
    vec_cnt++; if (dataD.srca !== 64'h10) begin err_cnt++; $display("FAIL lu_retry_srca: got %h want 10", dataD.srca); end
    in_valid = 1'b0; clear_fwd();
    tick();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; dataF.instr = I_ADD; rd1 = 64'd5; rd2 = 64'd7;
    tick();
    out_ready = 1'b0; dataF.instr = I_ADDI; rd1 = 64'd9;
    fwd_valid = 3'b001; fwd_dst[4:0] = 5'd2; fwd_data[63:0] = 64'h77;
    for (int c = 0; c < 3; c++) begin
      #1;
      vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, in_ready); end
      tick();
      vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, out_valid); end
      vec_cnt++; if (dataD.instr !== I_ADD) begin err_cnt++; $display("FAIL bp_instr[%0d]: got %h want %h", c, dataD.instr, I_ADD); end
      vec_cnt++; if (dataD.srca !== 64'd5) begin err_cnt++; $display("FAIL bp_srca[%0d]: got %h want 5", c, dataD.srca); end
      vec_cnt++; if (dataD.srcb !== 64'd7) begin err_cnt++; $display("FAIL bp_srcb[%0d]: got %h want 7", c, dataD.srcb); end
    end
    out_ready = 1'b1;
    #1;
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    tick();
    vec_cnt++; if (dataD.instr !== I_ADDI) begin err_cnt++; $display("FAIL bp_next_instr: got %h want %h", dataD.instr, I_ADDI); end
    vec_cnt++; if (dataD.srca !== 64'd9) begin err_cnt++; $display("FAIL bp_next_srca: got %h want 9", dataD.srca); end
    vec_cnt++; if (dataD.imm !== 64'd7) begin err_cnt++; $display("FAIL bp_next_imm: got %h want 7", dataD.imm); end
    vec_cnt++; if (dataD.ctl.use_imm !== 1'b1) begin err_cnt++; $display("FAIL bp_next_use_imm: got %b want 1", dataD.ctl.use_imm); end
    in_valid = 1'b0; clear_fwd();
    tick();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; dataF.instr = I_ADD; rd1 = 64'd5; rd2 = 64'd7;
    tick();
    flush = 1'b1; dataF.instr = I_SUB;
    #1;
    vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    vec_cnt++; if (dataD.instr !== I_ADD) begin err_cnt++; $display("FAIL flush_no_capture: got %h want %h", dataD.instr, I_ADD); end
    flush = 1'b0; in_valid = 1'b0;
    tick();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL post_flush_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_hold();
    in_valid = 1'b1; dataF.instr = I_ADD; rd1 = 64'd5; rd2 = 64'd7;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL hold_out_valid: got %b want 1", out_valid); end
    reset = 1'b1;
    tick();
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_hold_valid: got %b want 0", out_valid); end
    vec_cnt++; if (dataD !== '0) begin err_cnt++; $display("FAIL rst_hold_dataD: got %h want 0", dataD); end
    reset = 1'b0; out_ready = 1'b1;
    tick();
  endtask

`ifdef DECODE_ISSUE_PERF_EN
  task automatic test_perf();
    reset = 1'b1; in_valid = 1'b0; clear_fwd();
    tick();
    reset = 1'b0;
    vec_cnt++; if (stall_cycles !== 64'd0) begin err_cnt++; $display("FAIL perf_stall_reset: got %0d want 0", stall_cycles); end
    vec_cnt++; if (bubble_count !== 64'd0) begin err_cnt++; $display("FAIL perf_bubble_reset: got %0d want 0", bubble_count); end
    in_valid = 1'b1; dataF.instr = I_ADD; rd1 = 64'd5; rd2 = 64'd7;
    fwd_valid = 3'b001; fwd_dst[4:0] = 5'd1; fwd_pending = 3'b001;
    tick();
    tick();
    fwd_pending = 3'b000; fwd_data[63:0] = 64'h10;
    tick();
    clear_fwd(); dataF.instr = I_ADDI; out_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    vec_cnt++; if (stall_cycles !== 64'd3) begin err_cnt++; $display("FAIL perf_stall: got %0d want 3", stall_cycles); end
    vec_cnt++; if (bubble_count !== 64'd2) begin err_cnt++; $display("FAIL perf_bubble: got %0d want 2", bubble_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_reset_hold();
`ifdef DECODE_ISSUE_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
